shared_mem_arbiter: RTL

Round-robin arbiter placed directly upstream of the shared 256×8 IO/RAM register file. It collects read/write requests from NUM_REQ peripheral masters, grants one at a time, and drives that memory's single-port strobe interface (enable, address, data_in, write, read). For reads, it captures the memory's registered data_out and returns it to the winning master with a one-cycle valid pulse.

---
 rtl/shared_mem_arbiter_if.sv | 40 ++++
 rtl/shared_mem_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter_if.sv
// shared_mem_arbiter_if
//   Bundles the master-facing request/grant/response signals and the
//   single-port memory strobe bus that sit around shared_mem_arbiter.
//   slave  : the arbiter's view (takes requests and mem_data_out, drives grants and strobes)
//   master : the environment's view (requesting masters plus the memory)
//   Signals: req, req_write, req_addr, req_wdata (packed, master i at slice i),
//            gnt, rvalid, rdata, busy,
//            mem_enable, mem_write, mem_read, mem_address, mem_data_in, mem_data_out
interface shared_mem_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rdata;
   logic                      busy;
   logic                      mem_enable;
   logic                      mem_write;
   logic                      mem_read;
   logic [ADDR_W-1:0]         mem_address;
   logic [DATA_W-1:0]         mem_data_in;
   logic [DATA_W-1:0]         mem_data_out;

   modport slave (
      input  req, req_write, req_addr, req_wdata, mem_data_out,
      output gnt, rvalid, rdata, busy,
             mem_enable, mem_write, mem_read, mem_address, mem_data_in
   );

   modport master (
      output req, req_write, req_addr, req_wdata, mem_data_out,
      input  gnt, rvalid, rdata, busy,
             mem_enable, mem_write, mem_read, mem_address, mem_data_in
   );
endinterface

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter
//   Round-robin arbiter in front of the shared 256x8 IO/RAM register file.
//   Grants one of NUM_REQ masters at a time, issues its access on the memory's
//   single-port strobe bus and, for reads, returns the registered memory data
//   with a one-cycle rvalid pulse. Every output is registered.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - shared_mem_arbiter_if.slave: request fields in, gnt/rvalid/rdata/busy
//            and the mem_* strobes out, mem_data_out in
module shared_mem_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   shared_mem_arbiter_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   last, last_nxt;
   logic [IDX_W-1:0]   win, win_nxt;
   logic               wr_op, wr_op_nxt;
   logic [IDX_W-1:0]   pick_idx;

   logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

   logic [NUM_REQ-1:0] gnt_p0, gnt_p1;
   logic [NUM_REQ-1:0] rvalid_p0, rvalid_p1;
   logic [DATA_W-1:0]  rdata_p0, rdata_p1;
   logic               busy_p0, busy_p1;
   logic               en_p0, en_p1;
   logic               write_p0, write_p1;
   logic               read_p0, read_p1;
   logic [ADDR_W-1:0]  addr_p0, addr_p1;
   logic [DATA_W-1:0]  wdata_p0, wdata_p1;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
   end

   // Nearest requester strictly after ptr, wrapping modulo NUM_REQ. The walk
   // runs from the farthest candidate (ptr itself) to the nearest, so the last
   // hit is the nearest one. Idle masters are simply skipped.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   ptr);
      logic [IDX_W-1:0] sel;
      logic [IDX_W-1:0] cand;
      int               c;
      sel = ptr;
      for (int k = NUM_REQ; k >= 1; k--) begin
         c = int'(ptr) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         cand = IDX_W'(c);
         if (r[cand]) sel = cand;
      end
      return sel;
   endfunction

   assign pick_idx = rr_pick(bus.req, last);

   // Stage p0: decision from the current state and sampled request fields.
   // The mem_* registers double as the latched address/write data, since they
   // are only needed during the ISSUE cycle.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      win_nxt   = win;
      wr_op_nxt = wr_op;
      gnt_p0    = '0;
      rvalid_p0 = '0;
      rdata_p0  = rdata_p1;
      en_p0     = 1'b0;
      write_p0  = 1'b0;
      read_p0   = 1'b0;
      addr_p0   = '0;
      wdata_p0  = '0;

      case (state)
         IDLE: begin
            if (|bus.req) begin
               state_nxt        = ISSUE;
               last_nxt         = pick_idx;
               win_nxt          = pick_idx;
               wr_op_nxt        = bus.req_write[pick_idx];
               gnt_p0[pick_idx] = 1'b1;
               en_p0            = 1'b1;
               addr_p0          = addr_arr[pick_idx];
               if (bus.req_write[pick_idx]) begin
                  write_p0 = 1'b1;
                  wdata_p0 = wdata_arr[pick_idx];
               end else begin
                  read_p0  = 1'b1;
               end
            end
         end
         ISSUE: begin
            state_nxt = wr_op ? IDLE : WAIT;
         end
         WAIT: begin
            // The memory's registered data_out is valid now; capturing it here
            // makes rdata and rvalid appear together in RESP.
            rdata_p0       = bus.mem_data_out;
            rvalid_p0[win] = 1'b1;
            state_nxt      = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_p0 = (state_nxt != IDLE);
   end

   // Stage p1: registered control and outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= IDX_W'(NUM_REQ - 1);
         gnt_p1    <= '0;
         rvalid_p1 <= '0;
         rdata_p1  <= '0;
         busy_p1   <= 1'b0;
         en_p1     <= 1'b0;
         write_p1  <= 1'b0;
         read_p1   <= 1'b0;
         addr_p1   <= '0;
         wdata_p1  <= '0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         gnt_p1    <= gnt_p0;
         rvalid_p1 <= rvalid_p0;
         rdata_p1  <= rdata_p0;
         busy_p1   <= busy_p0;
         en_p1     <= en_p0;
         write_p1  <= write_p0;
         read_p1   <= read_p0;
         addr_p1   <= addr_p0;
         wdata_p1  <= wdata_p0;
      end
   end

   // Winner index and op type are only consulted after IDLE has loaded them.
   always_ff @(posedge clk) begin
      win   <= win_nxt;
      wr_op <= wr_op_nxt;
   end

   assign bus.gnt         = gnt_p1;
   assign bus.rvalid      = rvalid_p1;
   assign bus.rdata       = rdata_p1;
   assign bus.busy        = busy_p1;
   assign bus.mem_enable  = en_p1;
   assign bus.mem_write   = write_p1;
   assign bus.mem_read    = read_p1;
   assign bus.mem_address = addr_p1;
   assign bus.mem_data_in = wdata_p1;

endmodule
